// File: rtl/branch_target_buffer_pkg.sv
// Shared types and counter helpers for the branch target buffer.
// Direction counters are 2-bit saturating; new entries start at weakly-taken.
package bp_pkg;

   localparam int BP_WIDTH = 32;
   localparam int BP_TAGW  = 8;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } bp_ctr_e;

   typedef struct packed {
      logic                valid;
      logic [BP_TAGW-1:0]  tag;
      logic [BP_WIDTH-1:0] target;
      bp_ctr_e             ctr;
   } btb_entry_t;

   localparam bp_ctr_e BP_RESET_CTR = WNT;
   localparam bp_ctr_e BP_ALLOC_CTR = WT;

   function automatic bp_ctr_e bp_sat_inc(input bp_ctr_e c);
      bp_ctr_e r;
      case (c)
         SNT:     r = WNT;
         WNT:     r = WT;
         WT:      r = ST;
         ST:      r = ST;
         default: r = BP_RESET_CTR;
      endcase
      return r;
   endfunction

   function automatic bp_ctr_e bp_sat_dec(input bp_ctr_e c);
      bp_ctr_e r;
      case (c)
         SNT:     r = SNT;
         WNT:     r = SNT;
         WT:      r = WNT;
         ST:      r = WT;
         default: r = BP_RESET_CTR;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit direction counters: combinational fetch lookup,
// single-cycle writeback from EX. Flop storage so reset/flush clear every entry at once.
module branch_target_buffer
   import bp_pkg::*;
#(
   parameter int Width   = 32,
   parameter int Entries = 64,
   parameter int TagW    = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic [Width-1:0] pc_if_i,
   output logic             hit_o,
   output logic             pred_taken_o,
   output logic [Width-1:0] predicted_pc_o,
   input  logic             upd_valid_i,
   input  logic [Width-1:0] upd_pc_i,
   input  logic [Width-1:0] upd_target_i,
   input  logic             upd_taken_i
);

   localparam int IdxW = $clog2(Entries);

   logic             valid_r  [Entries];
   logic [TagW-1:0]  tag_r    [Entries];
   logic [Width-1:0] target_r [Entries];
   bp_ctr_e          ctr_r    [Entries];

   logic [IdxW-1:0]  lk_idx_s;
   logic [TagW-1:0]  lk_tag_s;
   logic [IdxW-1:0]  up_idx_s;
   logic [TagW-1:0]  up_tag_s;
   logic             up_hit_s;
   logic             unused_pc_bits_s;

   assign lk_idx_s = pc_if_i[IdxW+1:2];
   assign lk_tag_s = pc_if_i[IdxW+TagW+1:IdxW+2];
   assign up_idx_s = upd_pc_i[IdxW+1:2];
   assign up_tag_s = upd_pc_i[IdxW+TagW+1:IdxW+2];
   assign up_hit_s = valid_r[up_idx_s] && (tag_r[up_idx_s] == up_tag_s);

   // Upper PC bits are deliberately ignored, so aliasing between far-apart PCs is allowed.
   assign unused_pc_bits_s = ^{pc_if_i[1:0], pc_if_i[Width-1:IdxW+TagW+2],
                               upd_pc_i[1:0], upd_pc_i[Width-1:IdxW+TagW+2]};

   // Lookup reads pre-edge state; a same-cycle update is intentionally not bypassed.
   always_comb begin
      hit_o          = 1'b0;
      pred_taken_o   = 1'b0;
      predicted_pc_o = pc_if_i + Width'(3'd4);
      if (valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s)) begin
         hit_o = 1'b1;
         if (ctr_r[lk_idx_s][1]) begin
            pred_taken_o   = 1'b1;
            predicted_pc_o = target_r[lk_idx_s];
         end else begin
            pred_taken_o   = 1'b0;
         end
      end else begin
         hit_o = 1'b0;
      end
   end

   // Entry storage: reset beats flush beats update; not-taken misses never allocate.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < Entries; i++) begin
            valid_r[i]  <= 1'b0;
            tag_r[i]    <= '0;
            target_r[i] <= '0;
            ctr_r[i]    <= BP_RESET_CTR;
         end
      end else if (flush_i) begin
         for (int i = 0; i < Entries; i++) begin
            valid_r[i] <= 1'b0;
            ctr_r[i]   <= BP_RESET_CTR;
         end
      end else if (upd_valid_i) begin
         if (up_hit_s) begin
            if (upd_taken_i) begin
               ctr_r[up_idx_s]    <= bp_sat_inc(ctr_r[up_idx_s]);
               target_r[up_idx_s] <= upd_target_i;
            end else begin
               ctr_r[up_idx_s]    <= bp_sat_dec(ctr_r[up_idx_s]);
            end
         end else if (upd_taken_i) begin
            valid_r[up_idx_s]  <= 1'b1;
            tag_r[up_idx_s]    <= up_tag_s;
            target_r[up_idx_s] <= upd_target_i;
            ctr_r[up_idx_s]    <= BP_ALLOC_CTR;
         end else begin
            valid_r[up_idx_s]  <= valid_r[up_idx_s];
         end
      end else begin
         valid_r[up_idx_s] <= valid_r[up_idx_s];
      end
   end

endmodule
